// File: rtl/token_rings.sv
// Four-station token-ring arbiter: a one-hot token rotates around the stations,
// and the holder is granted while it requests, for at most HOLD_MAX cycles per visit.
module token_rings #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] datain,
    output logic [N-1:0] data
);

    localparam logic [3:0] LAST_GRANT = 4'(HOLD_MAX - 1);
    localparam logic [N-1:0] HOME_TOK = N'(1);

    logic [N-1:0] tok_reg;
    logic [N-1:0] tok_next;
    logic [3:0]   cnt_reg;
    logic [3:0]   cnt_next;
    logic [N-1:0] data_reg;
    logic [N-1:0] data_next;

    logic [N-1:0] tok_rot;
    logic [N-1:0] hold_req_vec;
    logic         holder_req;
    logic         tok_ok;

    // Rotate-left with wrap, and per-station "holder is requesting" terms.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_station
            assign tok_rot[gi]      = tok_reg[(gi + N - 1) % N];
            assign hold_req_vec[gi] = tok_reg[gi] & datain[gi];
        end
    endgenerate

    assign holder_req = |hold_req_vec;
    assign tok_ok     = (tok_reg != '0) && ((tok_reg & (tok_reg - HOME_TOK)) == '0);

    always_comb begin
        tok_next  = tok_reg;
        cnt_next  = cnt_reg;
        data_next = '0;
        if (en) begin
            if (!tok_ok) begin
                // A corrupted token is recovered by re-homing it at station 0.
                tok_next = HOME_TOK;
                cnt_next = '0;
            end else if (holder_req) begin
                data_next = tok_reg;
                if (cnt_reg >= LAST_GRANT) begin
                    tok_next = tok_rot;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end else begin
                tok_next = tok_rot;
                cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tok_reg  <= HOME_TOK;
            cnt_reg  <= '0;
            data_reg <= '0;
        end else begin
            tok_reg  <= tok_next;
            cnt_reg  <= cnt_next;
            data_reg <= data_next;
        end
    end

    assign data = data_reg;

endmodule

// File: tb/tb_token_rings.sv
// Randomized and directed bench for token_rings against an index/count model
// of the ring; one line per failed comparison, one summary line.
module tb_token_rings;

    localparam int N        = 4;
    localparam int HOLD_MAX = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] datain;
    logic [N-1:0] data;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: which station holds the token and how many grants it has used.
    int           m_holder;
    int           m_used;
    logic [N-1:0] m_data;

    always #5 clk = ~clk;

    token_rings #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .datain (datain),
        .data   (data)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: data=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic e, input logic [N-1:0] d);
        m_data = '0;
        if (r) begin
            m_holder = 0;
            m_used   = 0;
        end else if (e) begin
            if (d[m_holder]) begin
                m_data[m_holder] = 1'b1;
                m_used++;
                if (m_used == HOLD_MAX) begin
                    m_holder = (m_holder + 1) % N;
                    m_used   = 0;
                end
            end else begin
                m_holder = (m_holder + 1) % N;
                m_used   = 0;
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic [N-1:0] d);
        rst    = r;
        en     = e;
        datain = d;
        @(posedge clk);
        model_update(r, e, d);
        #1;
        check(tag, data, m_data);
    endtask

    initial begin
        logic [N-1:0] pat;
        rst = 1'b1; en = 1'b0; datain = '0;
        m_holder = 0; m_used = 0; m_data = '0;

        // Reset wins over en and requests, then first grant one cycle later.
        step("reset", 1'b1, 1'b1, 4'b1111);
        step("after_reset", 1'b0, 1'b1, 4'b0001);

        // Idle ring: token travels 8 stations back home, then grant.
        step("idle_reset", 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 8; i++) step("idle", 1'b0, 1'b1, 4'b0000);
        step("idle_return", 1'b0, 1'b1, 4'b0001);

        // Single requester: 4 grants, 3 idle, period 7.
        step("single_reset", 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 21; i++) begin
            step("single", 1'b0, 1'b1, 4'b0001);
            pat = ((i % 7) < 4) ? 4'b0001 : 4'b0000;
            check("single_pattern", data, pat);
        end

        // All requesting: each station gets HOLD_MAX grants in turn.
        step("all_reset", 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            step("all", 1'b0, 1'b1, 4'b1111);
            pat = '0;
            pat[(i / HOLD_MAX) % N] = 1'b1;
            check("all_pattern", data, pat);
        end

        // Enable gap: tenure count is preserved across en=0.
        step("gap_reset", 1'b1, 1'b0, 4'b0000);
        step("gap_on", 1'b0, 1'b1, 4'b0001);
        step("gap_on", 1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < 3; i++) step("gap_off", 1'b0, 1'b0, 4'b0001);
        step("gap_resume", 1'b0, 1'b1, 4'b0001);
        check("gap_resume_const", data, 4'b0001);
        step("gap_resume", 1'b0, 1'b1, 4'b0001);
        check("gap_resume_const", data, 4'b0001);
        step("gap_pass", 1'b0, 1'b1, 4'b0001);
        check("gap_pass_const", data, 4'b0000);

        // Request drop mid-visit, then reset during the next tenure.
        step("drop_reset", 1'b1, 1'b0, 4'b0000);
        step("drop_grant", 1'b0, 1'b1, 4'b0011);
        step("drop_grant", 1'b0, 1'b1, 4'b0011);
        step("drop_lost", 1'b0, 1'b1, 4'b0010);
        check("drop_lost_const", data, 4'b0000);
        step("drop_next", 1'b0, 1'b1, 4'b0010);
        check("drop_next_const", data, 4'b0010);
        step("mid_reset", 1'b1, 1'b1, 4'b0010);
        check("mid_reset_const", data, 4'b0000);
        step("mid_restart", 1'b0, 1'b1, 4'b0001);
        check("mid_restart_const", data, 4'b0001);

        // Randomized traffic with occasional disable and reset.
        for (int i = 0; i < 3000; i++) begin
            step("random", ($urandom % 60) == 0, ($urandom % 8) != 0, N'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
